// File: rtl/mem_data_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_data_bus_ctrl                                             |
// | Purpose  : MEM-stage data-bus master: one SRAM-like req/addr_ok/data_ok   |
// |            transaction per load/store, pipeline stall until completion.  |
// |            Define ADDR_MAP_EN for fixed kseg0/kseg1 address mapping.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_data_bus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        read_en,
    input  logic [3:0]        write_en,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [1:0]        size_in,
    input  logic              addr_err,
    input  logic              flush,
    input  logic              stall_in,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cancel_q, cancel_d;
    logic                issue;

    assign issue = mem_valid & ((|read_en) | (|write_en)) & ~addr_err & ~flush;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        size_d      = size_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cancel_d    = cancel_q;
        data_req    = 1'b0;
        rdata_valid = 1'b0;
        mem_stall   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = issue;
                if (issue) begin
                    addr_d  = mem_addr;
                    wr_d    = |write_en;
                    size_d  = size_in;
                    wstrb_d = write_en;
                    wdata_d = wdata_in;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Request must stay up until accepted, so a flush only marks it cancelled.
                data_req  = 1'b1;
                mem_stall = 1'b1;
                if (flush)
                    cancel_d = 1'b1;
                if (data_addr_ok)
                    state_d = DATA;
            end
            DATA: begin
                mem_stall = 1'b1;
                if (data_data_ok) begin
                    if (cancel_q || flush) begin
                        cancel_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        rdata_d = wr_q ? '0 : data_rdata;
                        state_d = DONE;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            DONE: begin
                rdata_valid = 1'b1;
                if (flush || !stall_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            wstrb_q  <= 4'b0000;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cancel_q <= cancel_d;
        end
    end

    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;
    assign rdata_out  = rdata_q;

`ifdef ADDR_MAP_EN
    // kseg0/kseg1 (top bits 10x) map to physical by clearing the three segment bits.
    assign data_addr = (addr_q[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, addr_q[ADDR_W-4:0]} : addr_q;
`else
    assign data_addr = addr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_data_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_data_bus_ctrl                                          |
// | Purpose  : Table-driven bench for mem_data_bus_ctrl (ADDR_MAP_EN aware). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_data_bus_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  read_en = '0;
    logic [3:0]  write_en = '0;
    logic [31:0] wdata_in = '0;
    logic [1:0]  size_in = '0;
    logic        addr_err = 1'b0;
    logic        flush = 1'b0;
    logic        stall_in = 1'b0;
    logic        data_req, data_wr, rdata_valid, mem_stall;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, rdata_out;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_data_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .read_en(read_en), .write_en(write_en), .wdata_in(wdata_in), .size_in(size_in),
        .addr_err(addr_err), .flush(flush), .stall_in(stall_in),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .rdata_out(rdata_out),
        .rdata_valid(rdata_valid), .mem_stall(mem_stall)
    );

`ifdef ADDR_MAP_EN
    localparam logic [31:0] A_K0   = 32'h0000_0010;
    localparam logic [31:0] A_BOOT = 32'h1FC0_0100;
`else
    localparam logic [31:0] A_K0   = 32'h8000_0010;
    localparam logic [31:0] A_BOOT = 32'h9FC0_0100;
`endif

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        aerr;
        logic        fl;
        logic        st;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_wr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rout;
        logic        e_rval;
        logic        e_stall;
    } vec_t;

    vec_t tv[40];

    function automatic vec_t mk(input logic v, input logic [31:0] addr, input logic [3:0] ren,
                                input logic [3:0] wen, input logic [31:0] wdata, input logic [1:0] size,
                                input logic aerr, input logic fl, input logic st, input logic aok,
                                input logic dok, input logic [31:0] rdata, input logic e_req,
                                input logic e_wr, input logic [3:0] e_wstrb, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic [31:0] e_rout,
                                input logic e_rval, input logic e_stall);
        vec_t t;
        t.v = v; t.addr = addr; t.ren = ren; t.wen = wen; t.wdata = wdata; t.size = size;
        t.aerr = aerr; t.fl = fl; t.st = st; t.aok = aok; t.dok = dok; t.rdata = rdata;
        t.e_req = e_req; t.e_wr = e_wr; t.e_wstrb = e_wstrb; t.e_addr = e_addr;
        t.e_wdata = e_wdata; t.e_rout = e_rout; t.e_rval = e_rval; t.e_stall = e_stall;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Store byte, addr_ok held off for 4 request cycles.
        tv[0]  = mk(1, 32'h3, 4'h0, 4'h8, 32'hABABABAB, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++)
            tv[i] = mk(1, 32'h3, 4'h0, 4'h8, 32'hABABABAB, 2'b00, 0, 0, 1, 0, 0, 0, 1, 1, 4'h8, 32'h3, 32'hABABABAB, 0, 0, 1);
        tv[5]  = mk(1, 32'h3, 4'h0, 4'h8, 32'hABABABAB, 2'b00, 0, 0, 1, 1, 0, 0, 1, 1, 4'h8, 32'h3, 32'hABABABAB, 0, 0, 1);
        tv[6]  = mk(1, 32'h3, 4'h0, 4'h8, 32'hABABABAB, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tv[7]  = mk(1, 32'h3, 4'h0, 4'h8, 32'hABABABAB, 2'b00, 0, 0, 1, 0, 1, 32'h77777777, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tv[8]  = mk(1, 32'h3, 4'h0, 4'h8, 32'hABABABAB, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0);
        tv[9]  = mk(0, 32'h0, 4'h0, 4'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        // Word load from kseg0 with minimum latency.
        tv[10] = mk(1, 32'h80000010, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tv[11] = mk(1, 32'h80000010, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 1, 0, 0, 1, 0, 4'h0, A_K0, 0, 0, 0, 1);
        tv[12] = mk(1, 32'h80000010, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 1, 32'h12345678, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        tv[13] = mk(1, 32'h80000010, 4'hF, 4'h0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h12345678, 1, 0);
        tv[14] = mk(0, 32'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h12345678, 0, 0);
        // Halfword load with address error never reaches the bus.
        tv[15] = mk(1, 32'h2, 4'h3, 4'h0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h12345678, 0, 0);
        tv[16] = mk(1, 32'h2, 4'h3, 4'h0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h12345678, 0, 0);
        // Boot-ROM load completing under a 5-cycle external stall.
        tv[17] = mk(1, 32'h9FC00100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h12345678, 0, 1);
        tv[18] = mk(1, 32'h9FC00100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 1, 0, 0, 1, 0, 4'h0, A_BOOT, 0, 32'h12345678, 0, 1);
        tv[19] = mk(1, 32'h9FC00100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 1, 32'hCAFEF00D, 0, 0, 4'h0, 0, 0, 32'h12345678, 0, 1);
        for (int i = 20; i <= 24; i++)
            tv[i] = mk(1, 32'h9FC00100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 1, 0);
        tv[25] = mk(1, 32'h9FC00100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 1, 0);
        tv[26] = mk(0, 32'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 0);
        // Flush while waiting for data: bus completes, result dropped.
        tv[27] = mk(1, 32'h100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 1);
        tv[28] = mk(1, 32'h100, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 1, 0, 0, 1, 0, 4'h0, 32'h100, 0, 32'hCAFEF00D, 0, 1);
        tv[29] = mk(1, 32'h100, 4'hF, 4'h0, 0, 2'b10, 0, 1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 1);
        tv[30] = mk(0, 32'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 1, 32'h55AA55AA, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 1);
        tv[31] = mk(0, 32'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 0);
        // Next load; addr_ok and data_ok together in REQ count as addr_ok only.
        tv[32] = mk(1, 32'h4, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 1);
        tv[33] = mk(1, 32'h4, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 1, 1, 32'hDEADDEAD, 1, 0, 4'h0, 32'h4, 0, 32'hCAFEF00D, 0, 1);
        tv[34] = mk(1, 32'h4, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 1);
        tv[35] = mk(1, 32'h4, 4'hF, 4'h0, 0, 2'b10, 0, 0, 1, 0, 1, 32'h0BADBEEF, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 1);
        tv[36] = mk(1, 32'h4, 4'hF, 4'h0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0BADBEEF, 1, 0);
        // Stray data_ok in IDLE, then a flushed instruction in IDLE.
        tv[37] = mk(0, 32'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 4'h0, 0, 0, 32'h0BADBEEF, 0, 0);
        tv[38] = mk(1, 32'h8, 4'hF, 4'h0, 0, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0BADBEEF, 0, 0);
        tv[39] = mk(0, 32'h0, 4'h0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0BADBEEF, 0, 0);

        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reset data_req", -1, {31'd0, data_req}, 32'd0);
        chk("reset data_wr", -1, {31'd0, data_wr}, 32'd0);
        chk("reset data_addr", -1, data_addr, 32'd0);
        chk("reset data_wstrb", -1, {28'd0, data_wstrb}, 32'd0);
        chk("reset rdata_out", -1, rdata_out, 32'd0);
        chk("reset rdata_valid", -1, {31'd0, rdata_valid}, 32'd0);
        chk("reset mem_stall", -1, {31'd0, mem_stall}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mem_valid = tv[i].v; mem_addr = tv[i].addr; read_en = tv[i].ren; write_en = tv[i].wen;
            wdata_in = tv[i].wdata; size_in = tv[i].size; addr_err = tv[i].aerr; flush = tv[i].fl;
            stall_in = tv[i].st; data_addr_ok = tv[i].aok; data_data_ok = tv[i].dok; data_rdata = tv[i].rdata;
            #1;
            chk("data_req", i, {31'd0, data_req}, {31'd0, tv[i].e_req});
            chk("mem_stall", i, {31'd0, mem_stall}, {31'd0, tv[i].e_stall});
            chk("rdata_valid", i, {31'd0, rdata_valid}, {31'd0, tv[i].e_rval});
            chk("rdata_out", i, rdata_out, tv[i].e_rout);
            if (tv[i].e_req) begin
                chk("data_wr", i, {31'd0, data_wr}, {31'd0, tv[i].e_wr});
                chk("data_wstrb", i, {28'd0, data_wstrb}, {28'd0, tv[i].e_wstrb});
                chk("data_addr", i, data_addr, tv[i].e_addr);
                chk("data_wdata", i, data_wdata, tv[i].e_wdata);
                chk("data_size", i, {30'd0, data_size}, {30'd0, tv[i].size});
            end
        end

        // Reset asserted mid-request, then a clean access after release.
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h20; read_en = 4'hF; write_en = 4'h0; size_in = 2'b10;
        stall_in = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0;
        begin : wait_req
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                @(posedge clk); #1;
                seen = data_req;
            end
            chk("req within bound", 100, {31'd0, seen}, 32'd1);
        end
        mem_valid = 1'b0; resetn = 1'b0;
        #1;
        chk("async reset data_req", 101, {31'd0, data_req}, 32'd0);
        chk("async reset mem_stall", 101, {31'd0, mem_stall}, 32'd0);
        chk("async reset rdata_out", 101, rdata_out, 32'd0);
        @(negedge clk);
        resetn = 1'b1; mem_valid = 1'b1;
        #1;
        chk("post-reset issue stall", 102, {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        chk("post-reset req", 103, {31'd0, data_req}, 32'd1);
        chk("post-reset addr", 103, data_addr, 32'h20);
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h600DF00D;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        chk("post-reset rdata_valid", 104, {31'd0, rdata_valid}, 32'd1);
        chk("post-reset rdata_out", 104, rdata_out, 32'h600DF00D);
        stall_in = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("post-reset back to idle", 105, {31'd0, rdata_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
